// File: rtl/an3_serial_tx.sv
// Bit-serial AN-code (A=3) transmitter: sends 3*data LSB-first as data + (data<<1),
// one sum bit per accepted beat, over a valid/ready serial link.
module an3_serial_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_bit,
  output logic              tx_last
);

  localparam int CW    = DATA_W + 2;
  localparam int CNT_W = $clog2(CW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CW - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  sh_q, sh_d;
  logic               prev_q, prev_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // sh_q[0] is bit i of data, prev_q is bit i-1 (i.e. bit i of data<<1).
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    sh_d     = sh_q;
    prev_d   = prev_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    tx_valid = 1'b0;
    tx_bit   = 1'b0;
    tx_last  = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = SEND;
          sh_d    = in_data;
          prev_d  = 1'b0;
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_bit   = sh_q[0] ^ prev_q ^ carry_q;
        tx_last  = (cnt_q == CNT_LAST);
        if (tx_ready) begin
          prev_d  = sh_q[0];
          sh_d    = sh_q >> 1;
          carry_d = (sh_q[0] & prev_q) | (sh_q[0] & carry_q) | (prev_q & carry_q);
          // Counter returns to 0 on the final beat so it never leaves 0..CW-1.
          if (tx_last) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      prev_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      sh_q    <= sh_d;
      prev_q  <= prev_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_an3_serial_tx.sv
// Self-checking bench for an3_serial_tx: a frame-level reference model compared every
// cycle, plus a receiver scoreboard that reassembles codewords and checks 3*data.
module tb_an3_serial_tx;

  localparam int DATA_W = 8;
  localparam int CW     = DATA_W + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_bit;
  logic              tx_last;

  an3_serial_tx #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_bit   (tx_bit),
    .tx_last  (tx_last)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a busy flag, the full codeword as an integer and the beat index.
  bit m_busy = 1'b0;
  int m_cw   = 0;
  int m_idx  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_idx  = 0;
    end else if (!m_busy) begin
      if (in_valid === 1'b1) begin
        m_busy = 1'b1;
        m_cw   = 3 * int'(in_data);
        m_idx  = 0;
      end
    end else if (tx_ready === 1'b1) begin
      if (m_idx == CW - 1) m_busy = 1'b0;
      else m_idx++;
    end
  end

  // Receiver side: reassemble accepted beats into a codeword.
  int          exp_q[$];
  int          frames_done = 0;
  logic [31:0] acc = '0;
  int          len = 0;
  logic [31:0] last_word = '0;
  int          last_len = 0;
  bit          held = 1'b0;
  logic        held_bit, held_last;
  bit          rdy_random = 1'b0;

  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(!m_busy));
    check("tx_valid", 32'(tx_valid), 32'(m_busy));
    check("tx_bit", 32'(tx_bit), m_busy ? 32'((m_cw >> m_idx) & 1) : 32'd0);
    check("tx_last", 32'(tx_last), 32'(m_busy && m_idx == CW - 1));
    if (!rst_n) begin
      acc  = '0;
      len  = 0;
      held = 1'b0;
    end else begin
      if (held && tx_valid) begin
        check("held_bit", 32'(tx_bit), 32'(held_bit));
        check("held_last", 32'(tx_last), 32'(held_last));
      end
      held      = tx_valid && !tx_ready;
      held_bit  = tx_bit;
      held_last = tx_last;
      if (tx_valid && tx_ready) begin
        if (tx_bit) acc = acc | (32'd1 << len);
        len++;
        if (tx_last) begin
          last_word = acc;
          last_len  = len;
          check("frame_len", 32'(len), 32'(CW));
          if (exp_q.size() > 0) check("codeword", acc, 32'(exp_q.pop_front()));
          else check("unexpected_frame", 32'(1), 32'(0));
          check("mod3", acc % 3, 32'd0);
          frames_done++;
          acc = '0;
          len = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    tx_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Offer a word and return one step after the handshake edge (cycle k+1).
  task automatic send(input logic [DATA_W-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(3 * int'(d));
    while (!in_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) check("send_timeout", 32'(n), 32'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Return once the frame after `start` completes; the DUT is then back in IDLE.
  task automatic wait_frame(input int start);
    int n = 0;
    while (frames_done == start && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) check("frame_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    int start;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_bit", 32'(tx_bit), 32'd0);
    check("rst_tx_last", 32'(tx_last), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 5 -> 15, first bit one cycle after the handshake.
    start = frames_done;
    send(8'd5);
    check("lat_tx_valid", 32'(tx_valid), 32'd1);
    check("lat_tx_bit", 32'(tx_bit), 32'd1);
    wait_frame(start);
    check("w5", last_word, 32'd15);
    check("w5_len", 32'(last_len), 32'd10);
    check("w5_ready_after", 32'(in_ready), 32'd1);

    start = frames_done;
    send(8'd255);
    wait_frame(start);
    check("w255", last_word, 32'd765);

    start = frames_done;
    send(8'd0);
    wait_frame(start);
    check("w0", last_word, 32'd0);
    check("w0_len", 32'(last_len), 32'd10);

    // Backpressure: random tx_ready, frame length counts accepted beats only.
    rdy_random = 1'b1;
    start = frames_done;
    send(8'd170);
    wait_frame(start);
    check("w170", last_word, 32'd510);
    check("w170_len", 32'(last_len), 32'd10);
    rdy_random = 1'b0;

    // in_valid during SEND is ignored; the held word is taken once back in IDLE.
    start = frames_done;
    send(8'd17);
    in_valid = 1'b1;
    in_data  = 8'd99;
    exp_q.push_back(297);
    repeat (3) begin
      check("busy_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    wait_frame(start);
    check("w17", last_word, 32'd51);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("w99_taken", 32'(tx_valid), 32'd1);
    wait_frame(start + 1);
    check("w99", last_word, 32'd297);

    // Reset after 4 beats of 200 aborts the frame.
    start = frames_done;
    send(8'd200);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_tx_valid", 32'(tx_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_tx_last", 32'(tx_last), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_no_frame", 32'(frames_done), 32'(start));
    send(8'd7);
    wait_frame(start);
    check("w7", last_word, 32'd21);

    // Exhaustive sweep under random backpressure.
    rdy_random = 1'b1;
    for (int i = 0; i < (1 << DATA_W); i++) begin
      start = frames_done;
      send(DATA_W'(i));
      wait_frame(start);
    end
    rdy_random = 1'b0;
    check("sweep_frames", 32'(frames_done), 32'(start + 1));
    check("sweep_last", last_word, 32'd765);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
